bcm_preimage_enum: RTL

- Inverse ("decoder") side of the team's 3-bit to 2-bit bcm code converter.
- Accepts one 2-bit code per transaction and streams out every 3-bit symbol that bcm maps to that code, in ascending order.
- Uses valid/ready handshakes on both sides.
- Sits after any stage carrying bcm codes and feeds consumers that need the candidate source symbols.

---
 rtl/bcm_pkg.sv | 26 ++
 rtl/bcm_match_mask.sv | 17 +
 rtl/bcm_preimage_enum.sv | 104 ++++++++++
 3 files changed

// File: rtl/bcm_pkg.sv
// Shared definitions for the bcm 3-bit to 2-bit code converter family.
package bcm_pkg;

    localparam int unsigned SYM_W  = 3;
    localparam int unsigned CODE_W = 2;
    localparam int unsigned N_SYM  = 1 << SYM_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        EMPTY = 2'd2
    } state_t;

    // Forward bcm mapping {i2,i1,i0} -> {o1,o0}.
    function automatic logic [CODE_W-1:0] bcm_f(input logic [SYM_W-1:0] sym);
        logic i2, i1, i0;
        logic o1, o0;
        i2 = sym[2];
        i1 = sym[1];
        i0 = sym[0];
        o1 = ~i1 | (~i0 & ~i2);
        o0 = (~i1 & ~i2) | (i0 & ~i1) | (~i0 & ~i2);
        return {o1, o0};
    endfunction

endpackage

// File: rtl/bcm_match_mask.sv
// Marks every source symbol whose forward bcm code equals the given code.
module bcm_match_mask
    import bcm_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [N_SYM-1:0]  mask
);

    // One forward evaluation and compare per candidate symbol.
    always_comb begin
        mask = '0;
        for (int unsigned k = 0; k < N_SYM; k++) begin
            mask[k] = (bcm_f(SYM_W'(k)) == code);
        end
    end

endmodule

// File: rtl/bcm_preimage_enum.sv
// Streams all preimage symbols of an accepted bcm code in ascending order,
// or a single empty beat when the code has no preimage.
module bcm_preimage_enum
    import bcm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SYM_W-1:0]  out_sym,
    output logic              out_last,
    output logic              out_empty
);

    state_t             state, state_nxt;
    logic [N_SYM-1:0]   mask, mask_nxt;
    logic [N_SYM-1:0]   match;
    logic [N_SYM-1:0]   low_bit;
    logic [SYM_W-1:0]   low_idx;
    logic               single;
    logic               accept;

    bcm_match_mask u_match (
        .code (in_code),
        .mask (match)
    );

    // Lowest-set-bit priority encoder and one-hot of that bit.
    always_comb begin
        low_idx = '0;
        low_bit = '0;
        for (int unsigned k = N_SYM; k > 0; k--) begin
            if (mask[k-1]) begin
                low_idx = SYM_W'(k-1);
                low_bit = '0;
                low_bit[k-1] = 1'b1;
            end
        end
    end

    // Exactly one bit remaining means the current beat is the last.
    always_comb begin
        single = (mask != '0) && ((mask & (mask - N_SYM'(1))) == '0);
    end

    assign in_ready = rst_n & (state == IDLE);
    assign accept   = in_valid & in_ready;

    // Next-state, next-mask and registered-state-derived outputs.
    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        out_valid = 1'b0;
        out_sym   = '0;
        out_last  = 1'b0;
        out_empty = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    mask_nxt  = match;
                    state_nxt = (match != '0) ? EMIT : EMPTY;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_sym   = low_idx;
                out_last  = single;
                if (out_ready) begin
                    mask_nxt = mask & ~low_bit;
                    if (single) begin
                        state_nxt = IDLE;
                    end
                end
            end
            EMPTY: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_empty = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                mask_nxt  = '0;
            end
        endcase
    end

    // State and mask registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            mask  <= '0;
        end else begin
            state <= state_nxt;
            mask  <= mask_nxt;
        end
    end

endmodule
